// File: rtl/sensor_sched_pkg.sv
// Shared types, command bytes and helpers for the sensor poll scheduler.
package sensor_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RECOVER
  } sched_state_t;

  localparam logic [7:0] CMD_TEMP = 8'h54;  // 'T'
  localparam logic [7:0] CMD_DIST = 8'h44;  // 'D'

  function automatic logic is_legal_cmd(input logic [7:0] cmd);
    return (cmd == CMD_TEMP) || (cmd == CMD_DIST);
  endfunction

endpackage

// File: rtl/period_timer.sv
// Free-running auto-poll period counter; tick pulses on the wrap cycle.
module period_timer #(
  parameter int unsigned PERIOD_CYCLES = 100_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = enable && (r_cnt == CNT_W'(PERIOD_CYCLES - 1));
  assign tick   = w_wrap;

  // Count while enabled, wrap at PERIOD_CYCLES-1, clear when disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_cnt <= '0;
    else if (!enable) r_cnt <= '0;
    else if (w_wrap)  r_cnt <= '0;
    else              r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Single-outstanding command sequencer between host/auto-poll sources and
// the sensor crossbar, with timeout recovery via a local crossbar reset.
module sensor_poll_scheduler
  import sensor_sched_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES  = 100_000_000,
  parameter int unsigned ACK_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] host_cmd,
  input  logic       host_cmd_valid,
  output logic       host_cmd_ready,
  output logic [7:0] xbar_cmd,
  output logic       xbar_cmd_valid,
  input  logic       xbar_ready_to_act,
  output logic       xbar_rst_n,
  output logic       busy,
  output logic       last_src,
  output logic       bad_cmd,
  output logic       timeout_err,
  output logic [7:0] err_cnt
);

  sched_state_t     r_state, w_next;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_started;
  logic             r_auto_pending;
  logic             r_auto_dist;     // 0: next auto command is T, 1: D
  logic             r_rec_second;
  logic             w_tick;
  logic             w_can_issue;
  logic             w_host_take;
  logic             w_issue;
  logic             w_auto_issue;
  logic             w_bad;
  logic             w_issue_src;
  logic [7:0]       w_issue_cmd;

  logic [7:0] r_xbar_cmd;
  logic       r_xbar_cmd_valid;
  logic       r_xbar_rst_n;
  logic       r_busy;
  logic       r_last_src;
  logic       r_bad_cmd;
  logic       r_timeout_err;
  logic [7:0] r_err_cnt;

  period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES),
    .CNT_W        (CNT_W)
  ) u_period_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (w_tick)
  );

  // r_started keeps the handshake low until the first edge after reset.
  assign w_can_issue    = r_started && xbar_ready_to_act && r_xbar_rst_n;
  assign host_cmd_ready = (r_state == IDLE) && w_can_issue;
  assign w_host_take    = host_cmd_valid && host_cmd_ready;

  // Next-state, arbitration and issue decode.
  always_comb begin
    w_next       = r_state;
    w_issue      = 1'b0;
    w_auto_issue = 1'b0;
    w_bad        = 1'b0;
    w_issue_src  = r_last_src;
    w_issue_cmd  = r_xbar_cmd;
    case (r_state)
      IDLE: begin
        if (w_host_take) begin
          if (is_legal_cmd(host_cmd)) begin
            w_next      = ISSUE;
            w_issue     = 1'b1;
            w_issue_cmd = host_cmd;
            w_issue_src = 1'b0;
          end else begin
            w_bad = 1'b1;
          end
        end else if (r_auto_pending && w_can_issue) begin
          w_next       = ISSUE;
          w_issue      = 1'b1;
          w_auto_issue = 1'b1;
          w_issue_cmd  = r_auto_dist ? CMD_DIST : CMD_TEMP;
          w_issue_src  = 1'b1;
        end
      end
      ISSUE:    w_next = WAIT_ACK;
      WAIT_ACK: begin
        if (!xbar_ready_to_act)                          w_next = WAIT_DONE;
        else if (r_to_cnt >= CNT_W'(ACK_CYCLES - 1))     w_next = RECOVER;
      end
      WAIT_DONE: begin
        if (xbar_ready_to_act)                           w_next = IDLE;
        else if (r_to_cnt >= CNT_W'(TIMEOUT_CYCLES - 1)) w_next = RECOVER;
      end
      RECOVER:  if (r_rec_second) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // State register plus the transaction timeout and recovery phase counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_to_cnt     <= '0;
      r_rec_second <= 1'b0;
      r_started    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_rec_second <= (r_state == RECOVER) && !r_rec_second;
      r_started    <= 1'b1;
      if (r_state == ISSUE)
        r_to_cnt <= '0;
      else if ((r_state == WAIT_ACK) || (r_state == WAIT_DONE))
        r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end

  // Auto-poll request latch and T/D alternation; untouched by recovery.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_auto_pending <= 1'b0;
      r_auto_dist    <= 1'b0;
    end else begin
      if (!enable)           r_auto_pending <= 1'b0;
      else if (w_tick)       r_auto_pending <= 1'b1;
      else if (w_auto_issue) r_auto_pending <= 1'b0;
      if (w_auto_issue) r_auto_dist <= ~r_auto_dist;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xbar_cmd       <= '0;
      r_xbar_cmd_valid <= 1'b0;
      r_xbar_rst_n     <= 1'b1;
      r_busy           <= 1'b0;
      r_last_src       <= 1'b0;
      r_bad_cmd        <= 1'b0;
      r_timeout_err    <= 1'b0;
      r_err_cnt        <= '0;
    end else begin
      r_xbar_cmd_valid <= w_issue;
      r_xbar_rst_n     <= (w_next != RECOVER);
      r_busy           <= (w_next != IDLE);
      r_bad_cmd        <= w_bad;
      r_timeout_err    <= (w_next == RECOVER) && (r_state != RECOVER);
      if (w_issue) begin
        r_xbar_cmd <= w_issue_cmd;
        r_last_src <= w_issue_src;
      end
      if ((w_next == RECOVER) && (r_state != RECOVER) && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign xbar_cmd       = r_xbar_cmd;
  assign xbar_cmd_valid = r_xbar_cmd_valid;
  assign xbar_rst_n     = r_xbar_rst_n & rst;
  assign busy           = r_busy;
  assign last_src       = r_last_src;
  assign bad_cmd        = r_bad_cmd;
  assign timeout_err    = r_timeout_err;
  assign err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Scoreboard bench for sensor_poll_scheduler with a simple crossbar model.
module tb_sensor_poll_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] host_cmd;
  logic       host_cmd_valid;
  logic       host_cmd_ready;
  logic [7:0] xbar_cmd;
  logic       xbar_cmd_valid;
  logic       xbar_ready_to_act;
  logic       xbar_rst_n;
  logic       busy;
  logic       last_src;
  logic       bad_cmd;
  logic       timeout_err;
  logic [7:0] err_cnt;

  sensor_poll_scheduler #(
    .PERIOD_CYCLES (20),
    .ACK_CYCLES    (4),
    .TIMEOUT_CYCLES(30),
    .CNT_W         (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .host_cmd         (host_cmd),
    .host_cmd_valid   (host_cmd_valid),
    .host_cmd_ready   (host_cmd_ready),
    .xbar_cmd         (xbar_cmd),
    .xbar_cmd_valid   (xbar_cmd_valid),
    .xbar_ready_to_act(xbar_ready_to_act),
    .xbar_rst_n       (xbar_rst_n),
    .busy             (busy),
    .last_src         (last_src),
    .bad_cmd          (bad_cmd),
    .timeout_err      (timeout_err),
    .err_cnt          (err_cnt)
  );

  typedef struct {
    logic [7:0] cmd;
    logic       src;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // crossbar model: 0 normal, 1 never drops ready, 2 drops but never raises
  int xb_mode  = 0;
  int xb_n     = 10;
  int xb_phase = 0;
  int xb_cnt   = 0;

  int k, e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s: got no event within bound, expected event", name);
  endtask

  task automatic push(input logic [7:0] cmd, input logic src, input int c);
    exp_t x;
    x.cmd = cmd;
    x.src = src;
    x.cyc = c;
    q.push_back(x);
  endtask

  // Crossbar: drops ready one cycle after valid, raises it xb_n cycles later.
  initial begin
    xbar_ready_to_act = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!xbar_rst_n) begin
        xbar_ready_to_act = 1'b1;
        xb_phase = 0;
      end else begin
        case (xb_phase)
          0: if (xbar_cmd_valid && xb_mode != 1) xb_phase = 1;
          1: begin
            xbar_ready_to_act = 1'b0;
            xb_cnt   = xb_n;
            xb_phase = (xb_mode == 2) ? 3 : 2;
          end
          2: begin
            xb_cnt--;
            if (xb_cnt == 0) begin
              xbar_ready_to_act = 1'b1;
              xb_phase = 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Monitor: every issue strobe pops and checks one scoreboard entry.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst && xbar_cmd_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_issue: got cmd %0h, expected no issue", xbar_cmd);
        end else begin
          x = q.pop_front();
          chk("issue_cmd", 32'(xbar_cmd), 32'(x.cmd));
          chk("issue_src", 32'(last_src), 32'(x.src));
          if (x.cyc >= 0) begin
            n_checks++;
            if (cyc >= x.cyc - 1 && cyc <= x.cyc + 1) n_pass++;
            else $display("FAIL issue_cycle: got cycle %0d, expected %0d (+/-1)", cyc, x.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_host(input logic [7:0] b, output int kc);
    int n = 0;
    @(negedge clk);
    host_cmd       = b;
    host_cmd_valid = 1'b1;
    while (!host_cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!host_cmd_ready) bound_fail("host_accept");
    @(posedge clk);
    #1;
    host_cmd_valid = 1'b0;
    kc = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) bound_fail("wait_idle");
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) bound_fail("wait_scoreboard");
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; host_cmd = 8'h00; host_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",        32'(busy), 0);
    chk("rst_last_src",    32'(last_src), 0);
    chk("rst_xbar_cmd",    32'(xbar_cmd), 0);
    chk("rst_cmd_valid",   32'(xbar_cmd_valid), 0);
    chk("rst_bad_cmd",     32'(bad_cmd), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_err_cnt",     32'(err_cnt), 0);
    chk("rst_host_ready",  32'(host_cmd_ready), 0);
    rst = 1'b1;
    #1;
    chk("ready_before_edge", 32'(host_cmd_ready), 0);
    chk("xbar_rst_n_idle",   32'(xbar_rst_n), 1);
    @(negedge clk);
    chk("ready_after_edge",  32'(host_cmd_ready), 1);

    // host command with enable low
    xb_mode = 0; xb_n = 10;
    send_host(8'h44, k);
    push(8'h44, 1'b0, k);
    @(negedge clk);
    chk("t1_busy_issue", 32'(busy), 1);
    repeat (11) @(negedge clk);
    chk("t1_busy_last", 32'(busy), 1);
    @(negedge clk);
    chk("t1_busy_done", 32'(busy), 0);

    // auto alternation
    xb_n = 5;
    @(posedge clk); #1;
    enable = 1'b1; e = cyc;
    push(8'h54, 1'b1, e + 21);
    push(8'h44, 1'b1, e + 41);
    push(8'h54, 1'b1, e + 61);
    push(8'h44, 1'b1, e + 81);
    wait_until(e + 85);
    enable = 1'b0;
    wait_sb(10);
    wait_idle(50);

    // illegal byte then a legal one
    send_host(8'h41, k);
    @(negedge clk);
    chk("t3_bad_pulse", 32'(bad_cmd), 1);
    chk("t3_not_busy",  32'(busy), 0);
    @(negedge clk);
    chk("t3_bad_clear", 32'(bad_cmd), 0);
    send_host(8'h54, k);
    push(8'h54, 1'b0, k);
    wait_idle(40);

    // host vs auto in the same IDLE cycle
    @(posedge clk); #1;
    enable = 1'b1; e = cyc;
    wait_until(e + 20);
    chk("t4_ready", 32'(host_cmd_ready), 1);
    host_cmd = 8'h44; host_cmd_valid = 1'b1;
    push(8'h44, 1'b0, e + 21);
    push(8'h54, 1'b1, e + 29);
    @(posedge clk); #1;
    host_cmd_valid = 1'b0;
    wait_sb(20);
    enable = 1'b0;
    wait_idle(30);

    // ack timeout
    xb_mode = 1;
    send_host(8'h54, k);
    push(8'h54, 1'b0, k);
    repeat (5) @(negedge clk);
    chk("t5a_rst_n_pre", 32'(xbar_rst_n), 1);
    @(negedge clk);
    chk("t5a_timeout_err", 32'(timeout_err), 1);
    chk("t5a_rst_n_low1",  32'(xbar_rst_n), 0);
    chk("t5a_err_cnt",     32'(err_cnt), 1);
    @(negedge clk);
    chk("t5a_err_clear",   32'(timeout_err), 0);
    chk("t5a_rst_n_low2",  32'(xbar_rst_n), 0);
    @(negedge clk);
    chk("t5a_rst_n_high",  32'(xbar_rst_n), 1);
    chk("t5a_idle",        32'(busy), 0);

    // done timeout
    xb_mode = 2;
    send_host(8'h44, k);
    push(8'h44, 1'b0, k);
    repeat (31) @(negedge clk);
    chk("t5b_no_err_yet", 32'(timeout_err), 0);
    chk("t5b_rst_n_pre",  32'(xbar_rst_n), 1);
    @(negedge clk);
    chk("t5b_timeout_err", 32'(timeout_err), 1);
    chk("t5b_err_cnt",     32'(err_cnt), 2);
    wait_idle(10);

    // saturation
    xb_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send_host(8'h54, k);
      push(8'h54, 1'b0, k);
      wait_idle(20);
    end
    wait_sb(5);
    chk("t5c_err_sat", 32'(err_cnt), 255);

    // reset during WAIT_DONE
    xb_mode = 0; xb_n = 10;
    @(posedge clk); #1;
    enable = 1'b1; e = cyc;
    push(8'h44, 1'b1, e + 21);
    wait_until(e + 24);
    @(negedge clk);
    chk("t6_busy_pre", 32'(busy), 1);
    chk("t6_sb_empty", q.size(), 0);
    rst = 1'b0; enable = 1'b0;
    #1;
    chk("t6_busy",        32'(busy), 0);
    chk("t6_last_src",    32'(last_src), 0);
    chk("t6_xbar_cmd",    32'(xbar_cmd), 0);
    chk("t6_cmd_valid",   32'(xbar_cmd_valid), 0);
    chk("t6_err_cnt",     32'(err_cnt), 0);
    chk("t6_timeout_err", 32'(timeout_err), 0);
    chk("t6_host_ready",  32'(host_cmd_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1; e = cyc;
    push(8'h54, 1'b1, e + 21);
    wait_sb(40);
    enable = 1'b0;
    wait_idle(30);

    chk("end_sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sensor_poll_scheduler.md
# sensor_poll_scheduler

Command sequencer in front of the sensor crossbar. It arbitrates between host commands from the UART receiver and an internal periodic poller that alternates temperature/moisture ('T') and distance ('D') requests. It issues exactly one command at a time to the crossbar and tracks completion through the crossbar's `ready_to_act`. If a transaction hangs, it recovers the crossbar with a local reset pulse.

## Interface
Parameters:
- `PERIOD_CYCLES`, default 100_000_000: auto-poll period in clk cycles (1 s at 100 MHz); minimum 2.
- `ACK_CYCLES`, default 4: maximum cycles from issue to crossbar `ready_to_act` falling.
- `TIMEOUT_CYCLES`, default 50_000_000: maximum cycles from issue to crossbar `ready_to_act` returning high.
- `CNT_W`, default 32: width of the period and timeout counters.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `enable` in 1: auto-poll enable.
- `host_cmd` in 8: ASCII command from the UART receiver.
- `host_cmd_valid` in 1: `host_cmd` is valid.
- `host_cmd_ready` out 1: scheduler accepts a host command this cycle.
- `xbar_cmd` out 8: command byte to the crossbar `uart_rx`.
- `xbar_cmd_valid` out 1: one-cycle strobe to the crossbar `valid_command`.
- `xbar_ready_to_act` in 1: crossbar `ready_to_act`.
- `xbar_rst_n` out 1: active-low reset to the crossbar; ANDed with `rst` at top level.
- `busy` out 1: a transaction is in flight.
- `last_src` out 1: source of the last issued command (0 = host, 1 = auto).
- `bad_cmd` out 1: one-cycle pulse when an illegal host byte is consumed.
- `timeout_err` out 1: one-cycle pulse on recovery.
- `err_cnt` out 8: saturating count of timeouts.

## Operation
- **States:** `IDLE`, `ISSUE`, `WAIT_ACK`, `WAIT_DONE`, `RECOVER`.
- **Host handshake:** `host_cmd_ready` = (state == `IDLE`) && `xbar_ready_to_act` && `xbar_rst_n`. A host byte is consumed when `host_cmd_valid` && `host_cmd_ready` are both high.
- **Legal commands:** 8'h54 ('T') and 8'h44 ('D') only. Any other consumed byte pulses `bad_cmd`, is dropped, and the state stays `IDLE`.
- **Arbitration in `IDLE`:** a legal host command wins. Otherwise, if `auto_pending` is set, the auto command is taken. Auto commands alternate T, D, T, …, starting with T after reset. The toggle advances only when an auto command is issued. `auto_pending` clears on issue.
- **Period timer:** counts while `enable` is high and wraps at `PERIOD_CYCLES`-1. On wrap it sets `auto_pending`. A wrap while `auto_pending` is already set is absorbed; there is no queueing beyond one.
- **`enable` low:** the period timer and `auto_pending` are cleared. An in-flight transaction still completes.
- **`ISSUE`** (1 cycle): `xbar_cmd_valid` = 1 and `xbar_cmd` holds the command. `xbar_cmd` stays stable until the next issue. Next state is `WAIT_ACK`, and the timeout counter is cleared.
- **`WAIT_ACK`:** on `xbar_ready_to_act` == 0, go to `WAIT_DONE`. If `ACK_CYCLES` elapse first, go to `RECOVER`.
- **`WAIT_DONE`:** on `xbar_ready_to_act` == 1, go to `IDLE`. If the counter reaches `TIMEOUT_CYCLES`, go to `RECOVER`. The counter runs from `ISSUE` exit through both wait states.
- **`RECOVER`** (2 cycles):
  - `xbar_rst_n` = 0 for both cycles.
  - `timeout_err` pulses in the first cycle.
  - `err_cnt` increments, saturating at 255.
  - Then go to `IDLE`. `auto_pending` and the T/D toggle are preserved, so the timed-out command is not retried.
- **`busy`:** 1 in `ISSUE`, `WAIT_ACK`, `WAIT_DONE`, `RECOVER`.
- **Simultaneous events:** a period wrap during a transaction sets `auto_pending`. A host command and auto pending in the same cycle: the host is issued and auto is issued after that transaction completes.
- **Mid-operation reset:** `rst` low clears everything immediately; the crossbar is reset by the same `rst`.

## Timing
- **Reset values:**
  - state `IDLE`
  - `host_cmd_ready` 0 until the first clk edge evaluates the combinational term
  - `xbar_cmd` 8'h00, `xbar_cmd_valid` 0, `xbar_rst_n` 1
  - `busy` 0, `last_src` 0, `bad_cmd` 0, `timeout_err` 0, `err_cnt` 0
  - period counter 0, `auto_pending` 0, toggle = T
- **Latency:**
  - Host byte consumed at edge k → `xbar_cmd_valid` high in cycle k+1.
  - Auto wrap at edge k while `IDLE` → `auto_pending` visible k+1 → `xbar_cmd_valid` in k+2.
- **Crossbar behaviour:** the crossbar drops `ready_to_act` one cycle after `valid_command`, so `WAIT_ACK` normally lasts 1 cycle.
- **Back-to-back:** the earliest next issue is 2 cycles after `ready_to_act` rises (`IDLE` decision, then `ISSUE`).
- **Outputs:** all outputs are registered except `host_cmd_ready`.

## Structure
- Package `sensor_sched_pkg`:
  - state enum `sched_state_t`
  - constants `CMD_TEMP` = 8'h54, `CMD_DIST` = 8'h44
  - function `is_legal_cmd`
- Sub-module `period_timer`:
  - params `PERIOD_CYCLES`, `CNT_W`
  - ports `clk`, `rst`, `enable`, `tick` (one-cycle pulse on wrap)
- The FSM, arbitration and timeout logic live in `sensor_poll_scheduler`.

## Test plan
Benches use `PERIOD_CYCLES`=20, `ACK_CYCLES`=4, `TIMEOUT_CYCLES`=30, with a crossbar model that drops `ready_to_act` 1 cycle after valid and raises it N cycles later.

1. **Host command:** `enable`=0, host 8'h44 valid → consumed, `xbar_cmd`=8'h44, one-cycle valid next cycle, `busy` until the model finishes (N=10), `last_src`=0.
2. **Auto alternation:** `enable`=1, no host, N=5 → issues T, D, T, D at cycles 21, 41, 61, 81 after enable (±1); `last_src`=1.
3. **Illegal byte:** host 8'h41 → `bad_cmd` pulse, no `xbar_cmd_valid`, state `IDLE`. A following 8'h54 is issued normally.
4. **Contention:** host 'D' valid in the same cycle `auto_pending` sets → 'D' issued first (host). Auto 'T' issued 2 cycles after `ready_to_act` rises.
5. **Timeouts:**
   - Model never drops `ready_to_act` → `RECOVER` after 4 cycles, `xbar_rst_n` low 2 cycles, `timeout_err` pulse, `err_cnt`=1.
   - Model drops `ready_to_act` but never raises it → recovery at cycle 30, `err_cnt`=2.
   - Force 300 timeouts → `err_cnt`=255.
6. **Reset mid-transaction:** `rst` low during `WAIT_DONE` → all outputs at reset values immediately. After release with `enable`=1, the first auto command is T at cycle ~21.
